// File: rtl/fetch_unit.sv
// PC generation and instruction fetch: drives word addresses to a free-running
// 2-cycle memory, buffers responses in a small FIFO and hands {pc, instr} to decode.
// Optional macro FETCH_PERF_CNT_EN adds fetch/drop performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ADDR_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic        imem_rdy,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Handshake toward decode: the head entry transfers on a cycle where
  // out_valid and out_ready are both high; out_valid never drops and out_*
  // never change while out_ready is low, except on a redirect flush.

  logic [31:0]      pc_q;
  logic             drop_next_q;
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic pop;
  logic push;

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO can still accept when the head leaves on the same edge.
  assign push      = imem_rdy & ~redirect_valid & ~drop_next_q & (~full | pop);

  assign imem_pc   = {{(32-ADDR_W){1'b0}}, pc_q[ADDR_W+1:2]};
  assign out_pc    = fifo_pc[rd_ptr_q];
  assign out_instr = fifo_instr[rd_ptr_q];

  // PC and stale-response tracking. pc only advances when its word is pushed,
  // so a dropped response is re-fetched from the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      drop_next_q <= 1'b1;
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc & 32'hFFFF_FFFC;
      drop_next_q <= 1'b1;
    end else if (imem_rdy) begin
      if (drop_next_q) begin
        drop_next_q <= 1'b0;
      end else if (push) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  // Pointers and occupancy; a redirect empties the buffer regardless of pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr_q]    <= pc_q;
      fifo_instr[wr_ptr_q] <= imem_instr;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        rsp_dropped;
  logic [31:0] fetch_cnt_q;
  logic [31:0] drop_cnt_q;

  // Every response that is not pushed is a drop, whatever the reason.
  assign rsp_dropped = imem_rdy & ~push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (push)        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (rsp_dropped) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_drop_cnt  = 32'd0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC-generation and instruction-fetch stage that sits directly upstream of the instruction-memory interface.
- Drives the word address into the memory and consumes its free-running rdy/INSTR response.
- Buffers fetched words in a small FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Handles sequential PC advance, branch/jump redirect, flush, and discard of stale memory responses.

Parameters:
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.
- FIFO_DEPTH, 2, entries in the fetch buffer (power of two, >=2).
- ADDR_W, 8, significant bits of the word address driven to memory; upper bits are driven 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_pc  out  32  word address to memory = {zeros, pc[ADDR_W+1:2]}.
- imem_rdy  in  1  memory response strobe; high for one cycle per completed read.
- imem_instr  in  32  memory read data; valid when imem_rdy=1.
- redirect_valid  in  1  branch/jump taken; load new PC and flush.
- redirect_pc  in  32  target byte PC; bits [1:0] are ignored (treated as 0).
- out_valid  out  1  FIFO head valid toward decode.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  byte PC of the head entry.
- out_instr  out  32  instruction word of the head entry.
- perf_fetch_cnt  out  32  accepted-fetch counter (optional feature).
- perf_drop_cnt  out  32  dropped-response counter (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, FIFO empty, out_valid=0, out_pc=0, out_instr=0.
  - drop_next=1, so the first post-reset response, whose PC is unknown, is discarded.
  - Perf counters = 0.
- imem_pc is combinational from the pc register and changes only on an edge where pc updates.
- Memory contract:
  - Memory samples imem_pc on an internal edge and returns the word with imem_rdy=1 the following cycle.
  - The memory has no request line; its responses arrive every 2 cycles regardless of fetch state.
- Response handling at a rising edge with imem_rdy=1 and redirect_valid=0:
  - drop_next=1: clear drop_next; discard the word; pc unchanged.
  - else if FIFO has room (count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop this edge): push {pc, imem_instr}; pc<=pc+4.
  - else (full, no pop): discard the word; pc unchanged, so the same address is re-fetched by the next response. Counts as a drop.
- Redirect (redirect_valid=1), highest priority:
  - pc<=redirect_pc & ~3; FIFO flushed (count=0, out_valid=0 next cycle); drop_next<=1.
  - Any imem_rdy in the same cycle is ignored.
  - The next response may carry the old-PC word, so it is always discarded. Cost is at most one extra 2-cycle response; correctness does not depend on the memory's phase.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - Push and pop on the same edge are allowed, including when full (count unchanged).
  - out_pc/out_instr are the head entry. Entries are registered; no combinational path from imem_instr to out_*.
  - Pop occurs when out_valid & out_ready.
  - out_valid must stay high and out_* stable while out_ready=0.
- Latency:
  - Word appears on out_* the cycle after the imem_rdy that delivered it.
  - Steady-state throughput: one instruction per 2 cycles, set by the memory rate.
- Wrap-around: pc+4 wraps modulo 2^32; imem_pc truncates to ADDR_W bits (address 255 wraps to 0).
- Reset asserted mid-operation: immediate return to reset state; any in-flight memory response is discarded via drop_next.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on every FIFO push.
  - perf_drop_cnt increments on every discarded imem_rdy response (drop_next, full, or redirect-cycle).
  - Both counters wrap at 2^32 and are reset by rst_n.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset release, model memory at 2-cycle rdy, out_ready=1 -> first response dropped; then out_pc=0x0,0x4,0x8 with memory words [0],[1],[2], one per 2 cycles; imem_pc=0,1,2,3.
- out_ready=0 for 10 cycles -> FIFO fills to 2 (pc 0x0, 0x4); further responses dropped and imem_pc held at 2; after release, 0x8 follows with no skipped or duplicated PC.
- redirect_valid one cycle with redirect_pc=0x43 while FIFO holds 2 -> out_valid=0 next cycle; next response dropped; next out_pc=0x40 with word [16].
- Redirect in the same cycle as imem_rdy=1 -> that word is not pushed; following response dropped; then target word delivered.
- pc=0x3FC (imem_pc=255) -> next imem_pc=0 with out_pc=0x400; push and pop on the same edge at full leaves count=2.
- With FETCH_PERF_CNT_EN, after scenario 2 -> perf_fetch_cnt equals the number of pushes and perf_drop_cnt equals reset drop + full drops; without the macro both read 0.
